seg_scan_decoder: RTL and testbench

- Receive-side counterpart of the multiplexed 7-segment display driver.
- Samples the scanned segment bus, digit-select lines and colon bit from the display pins.
- Decodes each digit's segment pattern back to a 4-bit value and assembles complete scan frames.
- Publishes each frame atomically with per-digit blank/invalid flags; used for board-level self-check and loopback monitoring of the clock display.

---
 rtl/seg_scan_decoder.sv | 182 ++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - receive-side decoder for a multiplexed 7-segment display scan
module seg_scan_decoder #(
    parameter int SETTLE         = 4,
    parameter int DIG_ACTIVE_LOW = 0,
    parameter int STALE_CYCLES   = 200000,
    parameter int STALE_W        = 18
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  dig_in,
    input  logic        dp_in,
    output logic [15:0] digits,
    output logic [3:0]  blank,
    output logic [3:0]  invalid,
    output logic        colon,
    output logic        frame_valid,
    output logic [7:0]  frame_cnt,
    output logic        stale
);

    localparam logic [3:0]         SETTLE_MAX = 4'(SETTLE);
    localparam logic [3:0]         SETTLE_M1  = 4'(SETTLE - 1);
    localparam logic [STALE_W-1:0] STALE_MAX  = STALE_W'(STALE_CYCLES);

    // Segment pattern -> {invalid, blank, nibble}
    function automatic logic [5:0] decode(input logic [6:0] s);
        logic [5:0] r;
        case (s)
            7'h3F:   r = {2'b00, 4'h0};
            7'h06:   r = {2'b00, 4'h1};
            7'h5B:   r = {2'b00, 4'h2};
            7'h4F:   r = {2'b00, 4'h3};
            7'h66:   r = {2'b00, 4'h4};
            7'h6D:   r = {2'b00, 4'h5};
            7'h7D:   r = {2'b00, 4'h6};
            7'h07:   r = {2'b00, 4'h7};
            7'h7F:   r = {2'b00, 4'h8};
            7'h6F:   r = {2'b00, 4'h9};
            7'h77:   r = {2'b00, 4'hA};
            7'h7C:   r = {2'b00, 4'hB};
            7'h39:   r = {2'b00, 4'hC};
            7'h5E:   r = {2'b00, 4'hD};
            7'h79:   r = {2'b00, 4'hE};
            7'h71:   r = {2'b00, 4'hF};
            7'h00:   r = {2'b01, 4'h0};
            default: r = {2'b10, 4'h0};
        endcase
        return r;
    endfunction

    logic [6:0]  seg_s1, seg_s2, seg_p;
    logic [3:0]  dig_s1, dig_s2, dig_p;
    logic        dp_s1, dp_s2, dp_p;
    logic [3:0]  dig_c;
    logic        one_hot, stable, capture, boundary;
    logic [3:0]  stab_cnt;
    logic        dwell_done;
    logic [1:0]  idx, last_idx;
    logic [5:0]  dec;
    logic [15:0] sh_val;
    logic [3:0]  sh_blank, sh_inv, seen;
    logic        sh_colon;
    logic [15:0] pub_digits;
    logic [3:0]  pub_blank, pub_inv;
    logic [STALE_W-1:0] stale_cnt;

    // Enables are normalised to active-high right after the synchronizer
    assign dig_c   = (DIG_ACTIVE_LOW != 0) ? ~dig_s2 : dig_s2;
    assign one_hot = (dig_c == 4'b0001) || (dig_c == 4'b0010) ||
                     (dig_c == 4'b0100) || (dig_c == 4'b1000);
    assign stable  = one_hot && ({seg_s2, dig_c, dp_s2} == {seg_p, dig_p, dp_p});
    assign capture = stable && !dwell_done && (stab_cnt == SETTLE_M1);
    assign dec      = decode(seg_s2);
    assign boundary = (seen != 4'b0) && (idx <= last_idx);

    // One-hot enable to digit index
    always_comb begin
        idx = 2'd0;
        case (dig_c)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
    end

    // Digits not scanned in the closing frame publish as blank zero
    always_comb begin
        pub_digits = 16'h0;
        for (int i = 0; i < 4; i++) begin
            pub_digits[4*i +: 4] = seen[i] ? sh_val[4*i +: 4] : 4'h0;
        end
        pub_blank = sh_blank | ~seen;
        pub_inv   = sh_inv & seen;
    end

    // Two-flop synchronizer plus one-cycle history for stability comparison
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seg_s1 <= '0; seg_s2 <= '0; seg_p <= '0;
            dig_s1 <= '0; dig_s2 <= '0; dig_p <= '0;
            dp_s1  <= 1'b0; dp_s2 <= 1'b0; dp_p <= 1'b0;
        end else begin
            seg_s1 <= seg_in; seg_s2 <= seg_s1; seg_p <= seg_s2;
            dig_s1 <= dig_in; dig_s2 <= dig_s1; dig_p <= dig_c;
            dp_s1  <= dp_in;  dp_s2  <= dp_s1;  dp_p  <= dp_s2;
        end
    end

    // Dwell counter: one capture per stable one-hot dwell
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stab_cnt   <= 4'd0;
            dwell_done <= 1'b0;
        end else if (!stable) begin
            stab_cnt   <= 4'd0;
            dwell_done <= 1'b0;
        end else begin
            if (stab_cnt < SETTLE_MAX) begin
                stab_cnt <= stab_cnt + 4'd1;
            end
            if (capture) begin
                dwell_done <= 1'b1;
            end
        end
    end

    // Shadow frame assembly and atomic publish on frame boundary
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            digits      <= 16'h0;
            blank       <= 4'hF;
            invalid     <= 4'h0;
            colon       <= 1'b0;
            frame_valid <= 1'b0;
            frame_cnt   <= 8'd0;
            sh_val      <= 16'h0;
            sh_blank    <= 4'h0;
            sh_inv      <= 4'h0;
            sh_colon    <= 1'b0;
            seen        <= 4'h0;
            last_idx    <= 2'd3;
        end else begin
            frame_valid <= 1'b0;
            if (capture) begin
                if (boundary) begin
                    digits      <= pub_digits;
                    blank       <= pub_blank;
                    invalid     <= pub_inv;
                    colon       <= sh_colon;
                    frame_cnt   <= frame_cnt + 8'd1;
                    frame_valid <= 1'b1;
                    seen        <= dig_c;
                    sh_colon    <= dp_s2;
                end else begin
                    seen        <= seen | dig_c;
                    sh_colon    <= sh_colon | dp_s2;
                end
                sh_val[{idx, 2'b00} +: 4] <= dec[3:0];
                sh_blank[idx]             <= dec[4];
                sh_inv[idx]               <= dec[5];
                last_idx                  <= idx;
            end
        end
    end

    // Cycles since last capture, saturating; stale while saturated
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stale_cnt <= '0;
            stale     <= 1'b0;
        end else if (capture) begin
            stale_cnt <= '0;
            stale     <= 1'b0;
        end else if (stale_cnt != STALE_MAX) begin
            stale_cnt <= stale_cnt + STALE_W'(1);
            stale     <= ((stale_cnt + STALE_W'(1)) == STALE_MAX);
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - directed self-checking bench for seg_scan_decoder
module tb_seg_scan_decoder;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  dig;
    logic [3:0]  dig_n;
    logic        dp_a, dp_b;

    logic [15:0] a_digits, b_digits;
    logic [3:0]  a_blank, b_blank, a_invalid, b_invalid;
    logic        a_colon, b_colon, a_fv, b_fv, a_stale, b_stale;
    logic [7:0]  a_fcnt, b_fcnt;

    int checks = 0;
    int failures = 0;
    int fv_a = 0;
    int max_stab;

    assign dig_n = ~dig;

    always #5 clock = ~clock;

    seg_scan_decoder #(.SETTLE(4), .DIG_ACTIVE_LOW(0), .STALE_CYCLES(100), .STALE_W(8)) dut_a (
        .clock(clock), .reset(reset), .seg_in(seg), .dig_in(dig), .dp_in(dp_a),
        .digits(a_digits), .blank(a_blank), .invalid(a_invalid), .colon(a_colon),
        .frame_valid(a_fv), .frame_cnt(a_fcnt), .stale(a_stale)
    );

    seg_scan_decoder #(.SETTLE(4), .DIG_ACTIVE_LOW(1), .STALE_CYCLES(100), .STALE_W(8)) dut_b (
        .clock(clock), .reset(reset), .seg_in(seg), .dig_in(dig_n), .dp_in(dp_b),
        .digits(b_digits), .blank(b_blank), .invalid(b_invalid), .colon(b_colon),
        .frame_valid(b_fv), .frame_cnt(b_fcnt), .stale(b_stale)
    );

    always @(negedge clock) begin
        if (a_fv) fv_a++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic scan(input logic [3:0] d, input logic [6:0] s, input logic pb, input int n);
        dig  = d;
        seg  = s;
        dp_b = pb;
        cyc(n);
    endtask

    initial begin
        seg = 7'h00; dig = 4'h0; dp_a = 1'b0; dp_b = 1'b0;
        cyc(3);
        check("rst_digits", a_digits, 16'h0);
        check("rst_blank", a_blank, 4'hF);
        check("rst_invalid", a_invalid, 4'h0);
        check("rst_colon", a_colon, 1'b0);
        check("rst_fv", a_fv, 1'b0);
        check("rst_fcnt", a_fcnt, 8'd0);
        check("rst_stale", a_stale, 1'b0);
        check("rst_b_blank", b_blank, 4'hF);
        reset = 1'b1;
        cyc(2);

        // Full scan 0..3 then digit 0 again closes the first frame
        scan(4'b0001, 7'h06, 1'b0, 20);
        scan(4'b0010, 7'h5B, 1'b0, 20);
        scan(4'b0100, 7'h4F, 1'b1, 20);
        scan(4'b1000, 7'h66, 1'b0, 20);
        check("s1_fcnt_pre", a_fcnt, 8'd0);
        scan(4'b0001, 7'h06, 1'b0, 20);
        check("s1_digits", a_digits, 16'h4321);
        check("s1_blank", a_blank, 4'h0);
        check("s1_invalid", a_invalid, 4'h0);
        check("s1_colon", a_colon, 1'b0);
        check("s1_fcnt", a_fcnt, 8'd1);
        check("s1_fv_pulses", fv_a, 1);
        check("al_digits", b_digits, 16'h4321);
        check("al_blank", b_blank, 4'h0);
        check("al_colon", b_colon, 1'b1);
        check("al_fcnt", b_fcnt, 8'd1);

        // Digit 2 dwell too short to settle
        scan(4'b0010, 7'h5B, 1'b0, 20);
        scan(4'b0100, 7'h4F, 1'b0, 4);
        scan(4'b1000, 7'h66, 1'b0, 20);
        scan(4'b0001, 7'h06, 1'b0, 20);
        check("s2_digits", a_digits, 16'h4021);
        check("s2_blank", a_blank, 4'b0100);
        check("s2_fcnt", a_fcnt, 8'd2);

        // Invalid pattern on digit 1, all-off on digit 3
        scan(4'b0010, 7'h55, 1'b0, 20);
        scan(4'b0100, 7'h4F, 1'b0, 20);
        scan(4'b1000, 7'h00, 1'b0, 20);
        scan(4'b0001, 7'h06, 1'b0, 20);
        check("s3_digits", a_digits, 16'h0301);
        check("s3_blank", a_blank, 4'b1000);
        check("s3_invalid", a_invalid, 4'b0010);
        check("s3_fv_pulses", fv_a, 3);
        check("s3_fcnt", a_fcnt, 8'd3);

        // Two-hot enables must never settle
        scan(4'b0010, 7'h5B, 1'b0, 20);
        dig = 4'b0011;
        cyc(5);
        max_stab = 0;
        for (int i = 0; i < 45; i++) begin
            cyc(1);
            if (int'(dut_a.stab_cnt) > max_stab) max_stab = int'(dut_a.stab_cnt);
        end
        check("s4_stab_max", max_stab, 0);
        check("s4_fcnt", a_fcnt, 8'd3);
        check("s4_fv_pulses", fv_a, 3);
        check("s4_invalid", a_invalid, 4'b0010);
        scan(4'b0100, 7'h4F, 1'b0, 20);
        scan(4'b1000, 7'h66, 1'b0, 20);
        scan(4'b0001, 7'h06, 1'b0, 20);
        check("s4_digits", a_digits, 16'h4321);
        check("s4_fcnt_after", a_fcnt, 8'd4);

        // Idle until stale; capture on digit 0 sampled 6 edges earlier
        dig = 4'h0;
        cyc(86);
        check("s5_stale_99", a_stale, 1'b0);
        cyc(1);
        check("s5_stale_100", a_stale, 1'b1);
        check("s5_digits_hold", a_digits, 16'h4321);
        check("s5_fcnt_hold", a_fcnt, 8'd4);
        dig = 4'b0001; seg = 7'h06;
        cyc(6);
        check("s5_stale_pre_cap", a_stale, 1'b1);
        check("s5_fv_pre_cap", a_fv, 1'b0);
        cyc(1);
        check("s5_stale_clr", a_stale, 1'b0);
        check("s5_fv_cap", a_fv, 1'b1);
        check("s5_digits_single", a_digits, 16'h0001);
        check("s5_blank_single", a_blank, 4'b1110);
        check("s5_fcnt", a_fcnt, 8'd5);
        cyc(1);
        check("s5_fv_one_cycle", a_fv, 1'b0);

        // Reset in the middle of a frame
        scan(4'b0010, 7'h5B, 1'b0, 20);
        scan(4'b0100, 7'h4F, 1'b1, 10);
        reset = 1'b0;
        #1;
        check("mr_digits", a_digits, 16'h0);
        check("mr_blank", a_blank, 4'hF);
        check("mr_fcnt", a_fcnt, 8'd0);
        check("mr_b_digits", b_digits, 16'h0);
        check("mr_b_colon", b_colon, 1'b0);
        cyc(2);
        reset = 1'b1;
        scan(4'b0001, 7'h06, 1'b0, 20);
        scan(4'b0010, 7'h5B, 1'b0, 20);
        scan(4'b0100, 7'h4F, 1'b0, 20);
        scan(4'b1000, 7'h66, 1'b0, 20);
        check("mr_no_publish", a_fcnt, 8'd0);
        check("mr_blank_hold", a_blank, 4'hF);
        scan(4'b0001, 7'h06, 1'b0, 20);
        check("mr_fcnt_after", a_fcnt, 8'd1);
        check("mr_digits_after", a_digits, 16'h4321);
        check("mr_b_fcnt_after", b_fcnt, 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
